elastic_pipeline_stage: RTL

//  Parametrised valid/ready pipeline of DEPTH elastic stages. It replaces fixed en/clear pipeline registers

---
 rtl/elastic_pipeline_stage.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/elastic_pipeline_stage.sv
// DEPTH series skid-buffer stages (main + skid each); DEPTH cycles latency, 1 beat/cycle, 2*DEPTH beats of storage.
// Backpressure stops one stage per cycle; in_ready is ~skid_v[0], a flop output, never combinational on out_ready.
module elastic_pipeline_stage #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 1,
  parameter bit CLEAR_DATA = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_data,
  output logic [$clog2(2*DEPTH+1)-1:0]   occupancy
);

  localparam int OCC_W = $clog2(2*DEPTH+1);

  generate
    if (DEPTH < 1 || WIDTH < 1) begin : g_bad_param
      $error("elastic_pipeline_stage: DEPTH and WIDTH must both be >= 1");
    end
  endgenerate

  logic [DEPTH-1:0] main_v, skid_v;
  logic [DEPTH-1:0] main_v_nxt, skid_v_nxt;
  logic [WIDTH-1:0] main_d     [DEPTH];
  logic [WIDTH-1:0] skid_d     [DEPTH];
  logic [WIDTH-1:0] main_d_nxt [DEPTH];
  logic [WIDTH-1:0] skid_d_nxt [DEPTH];

  // Index k is what feeds stage k; index DEPTH is the pipe output.
  logic [DEPTH:0]   up_v;
  logic [WIDTH-1:0] up_d [DEPTH+1];
  // Index k is stage k's own ready; index DEPTH is the consumer.
  logic [DEPTH:0]   dn_rdy;

  logic [DEPTH-1:0] up_fire, dn_fire;
  logic             in_fire, out_fire;
  logic [OCC_W-1:0] occ_nxt;

  assign up_v   = {main_v, in_valid};
  assign dn_rdy = {out_ready, ~skid_v};

  always_comb begin
    up_d[0] = in_data;
    for (int k = 0; k < DEPTH; k++) begin
      up_d[k+1] = main_d[k];
    end
  end

  assign up_fire = up_v[DEPTH-1:0] & ~skid_v;
  assign dn_fire = main_v & dn_rdy[DEPTH:1];

  assign in_ready  = dn_rdy[0];
  assign out_valid = up_v[DEPTH];
  assign out_data  = up_d[DEPTH];
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    main_v_nxt = main_v;
    skid_v_nxt = skid_v;
    for (int k = 0; k < DEPTH; k++) begin
      main_d_nxt[k] = main_d[k];
      skid_d_nxt[k] = skid_d[k];
    end

    for (int k = 0; k < DEPTH; k++) begin
      if (skid_v[k]) begin
        // Full stage: only drains, the skid beat slides into main.
        if (dn_fire[k]) begin
          main_d_nxt[k] = skid_d[k];
          skid_v_nxt[k] = 1'b0;
        end
      end else if (up_fire[k] && (!main_v[k] || dn_fire[k])) begin
        main_v_nxt[k] = 1'b1;
        main_d_nxt[k] = up_d[k];
      end else if (up_fire[k]) begin
        skid_v_nxt[k] = 1'b1;
        skid_d_nxt[k] = up_d[k];
      end else if (dn_fire[k]) begin
        main_v_nxt[k] = 1'b0;
      end
    end

    if (flush) begin
      main_v_nxt = '0;
      skid_v_nxt = '0;
      if (CLEAR_DATA) begin
        for (int k = 0; k < DEPTH; k++) begin
          main_d_nxt[k] = '0;
          skid_d_nxt[k] = '0;
        end
      end
    end
  end

  // Internal stage-to-stage moves never change the total, only the pipe ends do.
  always_comb begin
    occ_nxt = occupancy;
    if (flush) begin
      occ_nxt = '0;
    end else if (in_fire && !out_fire) begin
      occ_nxt = occupancy + OCC_W'(1);
    end else if (!in_fire && out_fire) begin
      occ_nxt = occupancy - OCC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_v    <= '0;
      skid_v    <= '0;
      occupancy <= '0;
    end else begin
      main_v    <= main_v_nxt;
      skid_v    <= skid_v_nxt;
      occupancy <= occ_nxt;
    end
  end

  generate
    if (CLEAR_DATA) begin : g_data_rst
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < DEPTH; k++) begin
            main_d[k] <= '0;
            skid_d[k] <= '0;
          end
        end else begin
          for (int k = 0; k < DEPTH; k++) begin
            main_d[k] <= main_d_nxt[k];
            skid_d[k] <= skid_d_nxt[k];
          end
        end
      end
    end else begin : g_data_norst
      always_ff @(posedge clk) begin
        for (int k = 0; k < DEPTH; k++) begin
          main_d[k] <= main_d_nxt[k];
          skid_d[k] <= skid_d_nxt[k];
        end
      end
    end
  endgenerate

endmodule
